// File: rtl/step_pulse_monitor_pkg.sv
// Shared types and constants for the six-motor step pulse monitor.
package step_pulse_monitor_pkg;

    localparam int unsigned N_MOTOR      = 6;
    localparam int unsigned MOT_W        = 3;
    localparam int unsigned CNT_W_DEF    = 10;
    localparam int unsigned MIN_HALF_DEF = 40;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        REPORT = 2'd2
    } state_t;

    function automatic logic is_onehot(input logic [N_MOTOR-1:0] v);
        return (v != '0) && ((v & (v - N_MOTOR'(1))) == '0);
    endfunction

    function automatic logic [MOT_W-1:0] onehot_idx(input logic [N_MOTOR-1:0] v);
        logic [MOT_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(N_MOTOR); i++) begin
            if (v[i]) idx = MOT_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/step_pulse_monitor_if.sv
// Motor-side pulse/enable/limit inputs and move/position/error reporting outputs.
interface step_pulse_monitor_if
    import step_pulse_monitor_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic [N_MOTOR-1:0] PU;
    logic [N_MOTOR-1:0] MF;
    logic [N_MOTOR-1:0] Stop;
    logic [MOT_W-1:0]   PosSel;
    logic               ErrClr;
    logic               Busy;
    logic               Done;
    logic [MOT_W-1:0]   DoneMotor;
    logic [CNT_W-1:0]   DoneCount;
    logic [CNT_W-1:0]   Pos;
    logic [N_MOTOR-1:0] Homed;
    logic               ErrMulti;
    logic               ErrStray;
    logic               ErrWidth;

    modport master (
        output PU, MF, Stop, PosSel, ErrClr,
        input  Busy, Done, DoneMotor, DoneCount, Pos, Homed, ErrMulti, ErrStray, ErrWidth
    );

    modport slave (
        input  PU, MF, Stop, PosSel, ErrClr,
        output Busy, Done, DoneMotor, DoneCount, Pos, Homed, ErrMulti, ErrStray, ErrWidth
    );
endinterface

// File: rtl/step_edge_chan.sv
// One motor channel: 2-FF synchronizers, PU falling-edge detect, Stop rising-edge
// detect and PU phase-width check; all outputs are aligned to the same cycle.
module step_edge_chan #(
    parameter int unsigned MIN_HALF = 40
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic pu,
    input  logic mf,
    input  logic stop,
    output logic step,
    output logic en,
    output logic stop_rise,
    output logic short_phase
);
    localparam int unsigned PH_W = $clog2(MIN_HALF + 1);

    logic [2:0]      pu_sh;
    logic [1:0]      mf_sh;
    logic [2:0]      stop_sh;
    logic [PH_W-1:0] ph_cnt;
    logic            pu_trans;
    logic            pu_fall;

    assign pu_trans = pu_sh[1] ^ pu_sh[2];
    assign pu_fall  = pu_sh[2] & ~pu_sh[1];

    // Phase counter starts saturated so the first edge after reset is never short.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            pu_sh       <= '1;
            mf_sh       <= '0;
            stop_sh     <= '0;
            en          <= 1'b0;
            step        <= 1'b0;
            stop_rise   <= 1'b0;
            short_phase <= 1'b0;
            ph_cnt      <= PH_W'(MIN_HALF);
        end else begin
            pu_sh       <= {pu_sh[1:0], pu};
            mf_sh       <= {mf_sh[0], mf};
            stop_sh     <= {stop_sh[1:0], stop};
            en          <= mf_sh[1];
            step        <= pu_fall;
            stop_rise   <= stop_sh[1] & ~stop_sh[2];
            short_phase <= pu_trans & mf_sh[1] & (ph_cnt < PH_W'(MIN_HALF));
            if (pu_trans) begin
                ph_cnt <= PH_W'(1);
            end else if (ph_cnt < PH_W'(MIN_HALF)) begin
                ph_cnt <= ph_cnt + PH_W'(1);
            end
        end
    end

endmodule

// File: rtl/step_pulse_monitor.sv
// Counts step pulses of the single enabled motor per move, tracks per-motor
// position and homing, and flags enable, stray-pulse and pulse-width errors.
module step_pulse_monitor
    import step_pulse_monitor_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned MIN_HALF = MIN_HALF_DEF
) (
    input  logic                 sysclk,
    input  logic                 rst_n,
    step_pulse_monitor_if.slave  bus
);
    logic [N_MOTOR-1:0] step;
    logic [N_MOTOR-1:0] en;
    logic [N_MOTOR-1:0] stop_rise;
    logic [N_MOTOR-1:0] short_ph;

    for (genvar g = 0; g < int'(N_MOTOR); g++) begin : g_chan
        step_edge_chan #(.MIN_HALF(MIN_HALF)) u_chan (
            .sysclk      (sysclk),
            .rst_n       (rst_n),
            .pu          (bus.PU[g]),
            .mf          (bus.MF[g]),
            .stop        (bus.Stop[g]),
            .step        (step[g]),
            .en          (en[g]),
            .stop_rise   (stop_rise[g]),
            .short_phase (short_ph[g])
        );
    end

    state_t             state, state_d;
    logic [MOT_W-1:0]   motor, motor_d;
    logic [CNT_W-1:0]   mcount, mcount_d;
    logic [N_MOTOR-1:0] sel;
    logic [N_MOTOR-1:0] cnt_mask;
    logic               count_c;
    logic               multi_c;
    logic               stray_c;
    logic               width_c;
    logic [CNT_W-1:0]   pos [N_MOTOR];

    assign sel      = N_MOTOR'(1) << motor;
    assign cnt_mask = count_c ? sel : '0;
    assign stray_c  = |(step & ~en & ~cnt_mask);
    assign width_c  = |short_ph;

    // A step on the latched motor in ACTIVE counts even in the cycle its enable drops.
    always_comb begin
        state_d  = state;
        motor_d  = motor;
        mcount_d = mcount;
        count_c  = 1'b0;
        multi_c  = 1'b0;
        unique case (state)
            IDLE: begin
                if (is_onehot(en)) begin
                    state_d  = ACTIVE;
                    motor_d  = onehot_idx(en);
                    mcount_d = '0;
                end else if (en != '0) begin
                    multi_c = 1'b1;
                end
            end
            ACTIVE: begin
                if (step[motor]) begin
                    count_c = 1'b1;
                    if (mcount != '1) mcount_d = mcount + CNT_W'(1);
                end
                if (en != sel) begin
                    state_d = REPORT;
                    if (en != '0) multi_c = 1'b1;
                end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            motor         <= '0;
            mcount        <= '0;
            bus.Busy      <= 1'b0;
            bus.Done      <= 1'b0;
            bus.DoneMotor <= '0;
            bus.DoneCount <= '0;
            bus.Homed     <= '0;
            bus.ErrMulti  <= 1'b0;
            bus.ErrStray  <= 1'b0;
            bus.ErrWidth  <= 1'b0;
            for (int i = 0; i < int'(N_MOTOR); i++) pos[i] <= '0;
        end else begin
            state    <= state_d;
            motor    <= motor_d;
            mcount   <= mcount_d;
            bus.Busy <= (state_d == ACTIVE);
            bus.Done <= (state_d == REPORT);
            if (state_d == REPORT) begin
                bus.DoneMotor <= motor_d;
                bus.DoneCount <= mcount_d;
            end
            bus.Homed <= bus.Homed | stop_rise;
            // Stop clear takes priority over a coincident step.
            for (int i = 0; i < int'(N_MOTOR); i++) begin
                if (stop_rise[i]) begin
                    pos[i] <= '0;
                end else if (count_c && (motor == MOT_W'(i))) begin
                    pos[i] <= pos[i] + CNT_W'(1);
                end
            end
            if (multi_c)         bus.ErrMulti <= 1'b1;
            else if (bus.ErrClr) bus.ErrMulti <= 1'b0;
            if (stray_c)         bus.ErrStray <= 1'b1;
            else if (bus.ErrClr) bus.ErrStray <= 1'b0;
            if (width_c)         bus.ErrWidth <= 1'b1;
            else if (bus.ErrClr) bus.ErrWidth <= 1'b0;
        end
    end

    always_comb begin
        bus.Pos = '0;
        for (int i = 0; i < int'(N_MOTOR); i++) begin
            if (bus.PosSel == MOT_W'(i)) bus.Pos = pos[i];
        end
    end

endmodule
